// File: rtl/vector_reader_pkg.sv
// rtl/vector_reader_pkg.sv - shared FSM states and width helpers for vector_reader
// Contents:
//   state_t       reader FSM encoding
//   index_width   bits of a per-lane element index
//   len_width     bits of a vector length (0..VECTOR_LENGTH)
//   keep_width    bits of the highest-valid-lane field
package vector_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int index_width(input int vector_length);
        return (vector_length > 1) ? $clog2(vector_length) : 1;
    endfunction

    function automatic int len_width(input int vector_length);
        return $clog2(vector_length + 1);
    endfunction

    function automatic int keep_width(input int numbers);
        return (numbers > 1) ? $clog2(numbers) : 1;
    endfunction

endpackage

// File: rtl/vector_reader_if.sv
// rtl/vector_reader_if.sv - command, RAM read and beat stream bundle of vector_reader
// Signals:
//   cmd_valid/cmd_ready/cmd_base/cmd_len   vector command handshake
//   busy                                   command in progress
//   rd_en/rd_addr/rd_data                  synchronous-read RAM port (1-cycle latency)
//   out_valid/out_ready/out_data/
//   out_index/out_last/out_keep            beat stream
// Modports: master = reader side, slave = command source / RAM / consumer side.
interface vector_reader_if #(
    parameter int NUMBERS       = 1,
    parameter int NUMBER_WIDTH  = 32,
    parameter int VECTOR_LENGTH = 32,
    parameter int ADDR_WIDTH    = 16
);
    localparam int IW = vector_reader_pkg::index_width(VECTOR_LENGTH);
    localparam int LW = vector_reader_pkg::len_width(VECTOR_LENGTH);
    localparam int KW = vector_reader_pkg::keep_width(NUMBERS);
    localparam int DW = NUMBER_WIDTH * NUMBERS;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_base;
    logic [LW-1:0]           cmd_len;
    logic                    busy;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DW-1:0]           rd_data;
    logic                    out_ready;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    logic [IW*NUMBERS-1:0]   out_index;
    logic                    out_last;
    logic [KW-1:0]           out_keep;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, rd_data, out_ready,
        output cmd_ready, busy, rd_en, rd_addr,
        output out_valid, out_data, out_index, out_last, out_keep
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, rd_data, out_ready,
        input  cmd_ready, busy, rd_en, rd_addr,
        input  out_valid, out_data, out_index, out_last, out_keep
    );

endinterface

// File: rtl/vector_reader_skid_fifo.sv
// rtl/vector_reader_skid_fifo.sv - 2-entry beat FIFO with registered head
// Ports:
//   clk, res     clock, asynchronous active-high reset
//   push         write push_data (caller never pushes into a full FIFO without popping)
//   push_data    beat to store
//   pop          drop the head (caller never pops an empty FIFO)
//   head         oldest entry, straight from a register
//   count        occupancy 0..2
module vector_reader_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] entry0_q;
    logic [WIDTH-1:0] entry1_q;
    logic [1:0]       count_q;

    // entry0_q is always the head, so a pop shifts entry1_q down.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) entry0_q <= push_data;
                    else                 entry1_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0_q <= push_data;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/vector_reader.sv
// rtl/vector_reader.sv - reads a vector from synchronous RAM and streams it as beats
// Ports:
//   clk    clock
//   res    asynchronous active-high reset
//   bus    vector_reader_if.master: command in, RAM read port, beat stream out
// One beat per cycle when out_ready stays high; reads stall under backpressure so
// that queued beats plus the read in flight never exceed the 2-entry FIFO.
module vector_reader
    import vector_reader_pkg::*;
#(
    parameter int NUMBERS       = 1,
    parameter int NUMBER_WIDTH  = 32,
    parameter int VECTOR_LENGTH = 32,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic            clk,
    input  logic            res,
    vector_reader_if.master bus
);
    localparam int IW = index_width(VECTOR_LENGTH);
    localparam int LW = len_width(VECTOR_LENGTH);
    localparam int KW = keep_width(NUMBERS);
    localparam int DW = NUMBER_WIDTH * NUMBERS;
    localparam int BW = DW + IW * NUMBERS + 1 + KW;

    typedef struct packed {
        logic [DW-1:0]         data;
        logic [IW*NUMBERS-1:0] index;
        logic                  last;
        logic [KW-1:0]         keep;
    } beat_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         beats_q;
    logic [LW-1:0]         issued_q;
    logic [LW-1:0]         recv_q;
    logic                  inflight_q;
    logic                  rd_en;
    logic                  start;
    logic                  valid;
    logic                  pop;
    logic                  credit;
    logic [2:0]            occupancy;
    logic [1:0]            fifo_count;
    logic [BW-1:0]         head_bits;
    beat_t                 head_beat;
    beat_t                 push_beat;

    assign head_beat = head_bits;
    assign valid     = (fifo_count != 2'd0);
    assign pop       = valid && bus.out_ready;
    assign start     = (state_q == ST_IDLE) && bus.cmd_valid && (bus.cmd_len != '0);

    // Counting the beat leaving this cycle lets a new read issue while the head
    // drains, which is what keeps the stream bubble-free with only 2 entries.
    assign occupancy = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
    assign credit    = (occupancy < 3'd2);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (credit) begin
                    rd_en = 1'b1;
                    if (issued_q == beats_q - LW'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_beat.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            beats_q    <= '0;
            issued_q   <= '0;
            recv_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (start) begin
                base_q   <= bus.cmd_base;
                len_q    <= bus.cmd_len;
                beats_q  <= LW'((int'(bus.cmd_len) + NUMBERS - 1) / NUMBERS);
                issued_q <= '0;
                recv_q   <= '0;
            end else begin
                if (rd_en)      issued_q <= issued_q + LW'(1);
                if (inflight_q) recv_q   <= recv_q + LW'(1);
            end
        end
    end

    // Beat metadata is attached as the RAM word arrives; lanes past the vector
    // end keep zero data and index.
    always_comb begin
        push_beat      = '0;
        push_beat.last = (recv_q == beats_q - LW'(1));
        push_beat.keep = push_beat.last ? KW'((int'(len_q) - 1) % NUMBERS)
                                        : KW'(NUMBERS - 1);
        for (int i = 0; i < NUMBERS; i++) begin
            if (int'(recv_q) * NUMBERS + i < int'(len_q)) begin
                push_beat.data[i*NUMBER_WIDTH +: NUMBER_WIDTH] =
                    bus.rd_data[i*NUMBER_WIDTH +: NUMBER_WIDTH];
                push_beat.index[i*IW +: IW] = IW'(int'(recv_q) * NUMBERS + i);
            end
        end
    end

    vector_reader_skid_fifo #(
        .WIDTH (BW)
    ) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (inflight_q),
        .push_data (push_beat),
        .pop       (pop),
        .head      (head_bits),
        .count     (fifo_count)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = base_q + ADDR_WIDTH'(issued_q);
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? head_beat.data  : '0;
    assign bus.out_index = valid ? head_beat.index : '0;
    assign bus.out_last  = valid ? head_beat.last  : 1'b0;
    assign bus.out_keep  = valid ? head_beat.keep  : '0;

endmodule

// File: tb/tb_vector_reader.sv
// tb/tb_vector_reader.sv - directed self-checking bench for vector_reader
module tb_vector_reader;

    logic clk;
    logic res;
    int   passed;
    int   total;

    vector_reader_if #(.NUMBERS(1), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32), .ADDR_WIDTH(16)) b1 ();
    vector_reader_if #(.NUMBERS(4), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32), .ADDR_WIDTH(16)) b4 ();
    vector_reader_if #(.NUMBERS(1), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32), .ADDR_WIDTH(4))  bw ();

    vector_reader #(.NUMBERS(1), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32), .ADDR_WIDTH(16))
        u_dut1 (.clk(clk), .res(res), .bus(b1.master));
    vector_reader #(.NUMBERS(4), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32), .ADDR_WIDTH(16))
        u_dut4 (.clk(clk), .res(res), .bus(b4.master));
    vector_reader #(.NUMBERS(1), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32), .ADDR_WIDTH(4))
        u_dutw (.clk(clk), .res(res), .bus(bw.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: word at address a holds 0x90+a; 4-lane words hold 0xB0000000|(a<<4)|lane.
    always @(posedge clk) begin
        if (b1.rd_en) b1.rd_data <= 32'h90 + 32'(b1.rd_addr);
        if (bw.rd_en) bw.rd_data <= 32'h90 + 32'(bw.rd_addr);
        if (b4.rd_en) begin
            for (int j = 0; j < 4; j++)
                b4.rd_data[j*32 +: 32] <= 32'hB000_0000 | (32'(b4.rd_addr) << 4) | 32'(j);
        end
    end

    task automatic cmd_b1(input logic [15:0] base, input logic [5:0] len);
        @(posedge clk); #1;
        b1.cmd_valid = 1'b1;
        b1.cmd_base  = base;
        b1.cmd_len   = len;
        @(posedge clk); #1;
        b1.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({b1.cmd_ready, b1.busy, b1.rd_en, b1.out_valid, b1.out_last} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b expected 10000",
                     {b1.cmd_ready, b1.busy, b1.rd_en, b1.out_valid, b1.out_last});
        else passed++;
        total++;
        if (b1.rd_addr !== 16'h0) $display("FAIL reset_rd_addr: got %h expected 0000", b1.rd_addr);
        else passed++;
        total++;
        if ({b1.out_data, b1.out_index, b1.out_keep} !== 38'h0)
            $display("FAIL reset_payload: got %h expected 0", {b1.out_data, b1.out_index, b1.out_keep});
        else passed++;
        total++;
        if ({b4.out_valid, b4.cmd_ready, bw.out_valid, bw.cmd_ready} !== 4'b0101)
            $display("FAIL reset_others: got %b expected 0101",
                     {b4.out_valid, b4.cmd_ready, bw.out_valid, bw.cmd_ready});
        else passed++;
        @(posedge clk); #1;
        res = 1'b0;
    endtask

    task automatic test_basic;
        logic [39:0] got, exp;
        b1.out_ready = 1'b1;
        cmd_b1(16'h0010, 6'd4);
        @(negedge clk);
        total++;
        if ({b1.busy, b1.rd_en, b1.rd_addr, b1.out_valid} !== {1'b1, 1'b1, 16'h0010, 1'b0})
            $display("FAIL basic_issue: got %h expected %h",
                     {b1.busy, b1.rd_en, b1.rd_addr, b1.out_valid}, {1'b1, 1'b1, 16'h0010, 1'b0});
        else passed++;
        @(negedge clk);
        total++;
        if (b1.out_valid !== 1'b0) $display("FAIL basic_latency: got %b expected 0", b1.out_valid);
        else passed++;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            got = {b1.out_valid, b1.out_data, b1.out_index, b1.out_last, b1.out_keep};
            exp = {1'b1, 32'hA0 + 32'(b), 5'(b), (b == 3), 1'b0};
            total++;
            if (got !== exp) $display("FAIL basic_beat%0d: got %h expected %h", b, got, exp);
            else passed++;
        end
        @(negedge clk);
        total++;
        if ({b1.cmd_ready, b1.busy, b1.out_valid} !== 3'b100)
            $display("FAIL basic_done: got %b expected 100", {b1.cmd_ready, b1.busy, b1.out_valid});
        else passed++;
    endtask

    task automatic test_lanes;
        logic [150:0] got, exp;
        int k;
        @(posedge clk); #1;
        b4.cmd_valid = 1'b1;
        b4.cmd_base  = 16'h0020;
        b4.cmd_len   = 6'd6;
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.cmd_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!b4.out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (b4.out_valid !== 1'b1) $display("FAIL lanes_wait: got %b expected 1", b4.out_valid);
        else passed++;
        got = {b4.out_data, b4.out_index, b4.out_last, b4.out_keep};
        exp = {32'hB000_0203, 32'hB000_0202, 32'hB000_0201, 32'hB000_0200,
               5'd3, 5'd2, 5'd1, 5'd0, 1'b0, 2'd3};
        total++;
        if (got !== exp) $display("FAIL lanes_beat0: got %h expected %h", got, exp);
        else passed++;
        @(negedge clk);
        got = {b4.out_data, b4.out_index, b4.out_last, b4.out_keep};
        exp = {32'h0, 32'h0, 32'hB000_0211, 32'hB000_0210,
               5'd0, 5'd0, 5'd5, 5'd4, 1'b1, 2'd1};
        total++;
        if (got !== exp || b4.out_valid !== 1'b1)
            $display("FAIL lanes_beat1: got %h expected %h (valid %b)", got, exp, b4.out_valid);
        else passed++;
        @(negedge clk);
        total++;
        if ({b4.busy, b4.out_valid} !== 2'b00)
            $display("FAIL lanes_done: got %b expected 00", {b4.busy, b4.out_valid});
        else passed++;
    endtask

    task automatic test_backpressure;
        int          n, issued, popped, max_out, c;
        logic        held;
        logic [38:0] cur, held_bits, exp;
        n = 0; issued = 0; popped = 0; max_out = 0; held = 1'b0; held_bits = '0;
        b1.out_ready = 1'b1;
        cmd_b1(16'h0040, 6'd8);
        c = 0;
        while (n < 8 && c < 100) begin
            if (c < 12)      b1.out_ready = (c % 2 == 0);
            else if (c < 17) b1.out_ready = 1'b0;
            else             b1.out_ready = 1'b1;
            @(negedge clk);
            if (issued - popped > max_out) max_out = issued - popped;
            cur = {b1.out_data, b1.out_index, b1.out_last, b1.out_keep};
            if (held) begin
                total++;
                if (b1.out_valid !== 1'b1 || cur !== held_bits)
                    $display("FAIL bp_hold: got %h expected %h (valid %b)", cur, held_bits, b1.out_valid);
                else passed++;
            end
            if (b1.out_valid) begin
                if (b1.out_ready) begin
                    exp = {32'hD0 + 32'(n), 5'(n), (n == 7), 1'b0};
                    total++;
                    if (cur !== exp) $display("FAIL bp_beat%0d: got %h expected %h", n, cur, exp);
                    else passed++;
                    n++;
                    popped++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_bits = cur;
                end
            end
            if (b1.rd_en) issued++;
            c++;
            @(posedge clk); #1;
        end
        total++;
        if (n !== 8) $display("FAIL bp_count: got %0d beats expected 8", n);
        else passed++;
        total++;
        if (max_out > 2 || issued !== 8)
            $display("FAIL bp_outstanding: got max %0d reads %0d expected max<=2 reads 8", max_out, issued);
        else passed++;
        @(negedge clk);
        total++;
        if ({b1.busy, b1.out_valid} !== 2'b00)
            $display("FAIL bp_done: got %b expected 00", {b1.busy, b1.out_valid});
        else passed++;
    endtask

    task automatic test_len_zero;
        @(posedge clk); #1;
        b1.cmd_valid = 1'b1;
        b1.cmd_base  = 16'h0005;
        b1.cmd_len   = 6'd0;
        @(negedge clk);
        total++;
        if (b1.cmd_ready !== 1'b1) $display("FAIL zero_ready: got %b expected 1", b1.cmd_ready);
        else passed++;
        @(posedge clk); #1;
        b1.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({b1.cmd_ready, b1.busy, b1.rd_en, b1.out_valid} !== 4'b1000)
                $display("FAIL zero_idle%0d: got %b expected 1000", k,
                         {b1.cmd_ready, b1.busy, b1.rd_en, b1.out_valid});
            else passed++;
        end
    endtask

    task automatic test_wrap;
        logic [3:0]  addrs [8];
        logic [31:0] datas [8];
        logic [3:0]  exp_addr [4];
        logic [31:0] exp_data [4];
        int nr, nb;
        exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        exp_data = '{32'h9E, 32'h9F, 32'h90, 32'h91};
        nr = 0; nb = 0;
        @(posedge clk); #1;
        bw.cmd_valid = 1'b1;
        bw.cmd_base  = 4'd14;
        bw.cmd_len   = 6'd4;
        bw.out_ready = 1'b1;
        @(posedge clk); #1;
        bw.cmd_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bw.rd_en && nr < 8) begin addrs[nr] = bw.rd_addr; nr++; end
            if (bw.out_valid && nb < 8) begin datas[nb] = bw.out_data; nb++; end
        end
        total++;
        if (nr !== 4 || nb !== 4) $display("FAIL wrap_count: got reads %0d beats %0d expected 4 4", nr, nb);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (addrs[k] !== exp_addr[k] || datas[k] !== exp_data[k])
                $display("FAIL wrap_%0d: got addr %0d data %h expected addr %0d data %h",
                         k, addrs[k], datas[k], exp_addr[k], exp_data[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        logic [38:0] got, exp;
        b1.out_ready = 1'b0;
        cmd_b1(16'h0060, 6'd8);
        repeat (5) @(negedge clk);
        total++;
        if (b1.out_valid !== 1'b1) $display("FAIL rmid_pending: got %b expected 1", b1.out_valid);
        else passed++;
        #2 res = 1'b1;
        #1;
        total++;
        if ({b1.out_valid, b1.busy, b1.cmd_ready} !== 3'b001)
            $display("FAIL rmid_async: got %b expected 001", {b1.out_valid, b1.busy, b1.cmd_ready});
        else passed++;
        @(posedge clk); #1;
        res = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({b1.out_valid, b1.busy, b1.rd_en} !== 3'b000)
            $display("FAIL rmid_quiet: got %b expected 000", {b1.out_valid, b1.busy, b1.rd_en});
        else passed++;
        b1.out_ready = 1'b1;
        cmd_b1(16'h0070, 6'd2);
        repeat (2) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            got = {b1.out_data, b1.out_index, b1.out_last, b1.out_keep};
            exp = {32'h100 + 32'(b), 5'(b), (b == 1), 1'b0};
            total++;
            if (got !== exp || b1.out_valid !== 1'b1)
                $display("FAIL rmid_beat%0d: got %h expected %h (valid %b)", b, got, exp, b1.out_valid);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        res    = 1'b1;
        b1.cmd_valid = 1'b0; b1.cmd_base = '0; b1.cmd_len = '0; b1.out_ready = 1'b0;
        b4.cmd_valid = 1'b0; b4.cmd_base = '0; b4.cmd_len = '0; b4.out_ready = 1'b0;
        bw.cmd_valid = 1'b0; bw.cmd_base = '0; bw.cmd_len = '0; bw.out_ready = 1'b0;
        test_reset;
        test_basic;
        test_lanes;
        test_backpressure;
        test_len_zero;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
